// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and
// the line levels that mark frame boundaries.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/frame_sipo.sv
// Serial-in parallel-out payload register; bits enter at the MSB and move
// right, so an LSB-first stream ends up in natural bit order.
module frame_sipo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         din,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[W-1:1]};
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Bit-strobed serial frame receiver: start bit, LSB-first payload, optional
// even parity, stop bit; delivers frames on a valid/ready output register.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    input  logic              bit_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_perr,
    output logic              frm_err,
    output logic              ovr_err,
    output logic              busy
);

    localparam int                CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               perr;
    logic [DATA_W-1:0]  payload;
    logic               shift_en;
    logic               shift_clr;

    assign shift_en  = bit_en && (state == DATA);
    assign shift_clr = bit_en && (state == IDLE) && (sin == START_BIT);
    assign busy      = (state != IDLE);

    frame_sipo #(.W(DATA_W)) u_sipo (
        .clk   (clk),
        .reset (reset),
        .en    (shift_en),
        .clr   (shift_clr),
        .din   (sin),
        .q     (payload)
    );

    // NOTE: every register, including the output holding register, is cleared
    // by the asynchronous reset so no stale frame survives a mid-frame reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            perr      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_perr  <= 1'b0;
            frm_err   <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (sin == START_BIT) begin
                            state <= DATA;
                            cnt   <= '0;
                            perr  <= 1'b0;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= PARITY_EN ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        // Even parity: payload plus parity bit must XOR to 0.
                        perr  <= (^payload) ^ sin;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (sin == STOP_BIT) begin
                            // A completing frame may replace one being accepted this cycle.
                            if (!out_valid || out_ready) begin
                                out_data  <= payload;
                                out_perr  <= perr;
                                out_valid <= 1'b1;
                            end else begin
                                ovr_err <= 1'b1;
                            end
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx (DATA_W=8, even parity).
module tb_serial_frame_rx;

    logic       clk;
    logic       reset;
    logic       sin;
    logic       bit_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_perr;
    logic       frm_err;
    logic       ovr_err;
    logic       busy;

    int checks;
    int errors;

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .bit_en    (bit_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_perr  (out_perr),
        .frm_err   (frm_err),
        .ovr_err   (ovr_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Idle gap cycles drive sin=1 with bit_en=0 to prove the strobe gates sampling.
    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            bit_en = 1'b0;
            sin    = 1'b1;
            @(negedge clk);
        end
        bit_en = 1'b1;
        sin    = b;
        @(negedge clk);
    endtask

    // Start bit, payload LSB first, even parity (optionally inverted); no stop bit.
    task automatic send_body(input logic [7:0] data, input logic flip, input int gap);
        send_bit(1'b1, gap);
        for (int i = 0; i < 8; i++) begin
            send_bit(data[i], gap);
        end
        send_bit((^data) ^ flip, gap);
    endtask

    task automatic idle_cycle();
        bit_en = 1'b0;
        sin    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        sin       = 1'b0;
        bit_en    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_out_data",  out_data,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_errs",      {frm_err, ovr_err, out_perr}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Idle line with strobes must not start a frame.
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        check("idle_busy", busy, 0);

        // 0xA5, good parity, continuous strobe.
        send_body(8'hA5, 1'b0, 0);
        check("a5_pre_stop_valid", out_valid, 0);
        check("a5_pre_stop_busy",  busy,      1);
        send_bit(1'b0, 0);
        check("a5_valid", out_valid, 1);
        check("a5_data",  out_data,  8'hA5);
        check("a5_perr",  out_perr,  0);
        check("a5_busy",  busy,      0);
        idle_cycle();
        check("a5_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        idle_cycle();
        check("a5_accept_valid", out_valid, 0);
        out_ready = 1'b0;

        // 0xA5 with inverted parity bit.
        send_body(8'hA5, 1'b1, 0);
        send_bit(1'b0, 0);
        check("perr_valid", out_valid, 1);
        check("perr_data",  out_data,  8'hA5);
        check("perr_flag",  out_perr,  1);
        check("perr_frm",   frm_err,   0);
        out_ready = 1'b1;
        idle_cycle();
        check("perr_accept_valid", out_valid, 0);
        out_ready = 1'b0;

        // 0x3C with bad stop bit.
        send_body(8'h3C, 1'b0, 0);
        send_bit(1'b1, 0);
        check("frm_pulse", frm_err,   1);
        check("frm_valid", out_valid, 0);
        check("frm_busy",  busy,      0);
        check("frm_ovr",   ovr_err,   0);
        idle_cycle();
        check("frm_one_cycle", frm_err, 0);

        // Back-to-back 0x11 then 0x22 with output stalled.
        send_body(8'h11, 1'b0, 0);
        send_bit(1'b0, 0);
        check("b2b_first_valid", out_valid, 1);
        check("b2b_first_data",  out_data,  8'h11);
        check("b2b_first_ovr",   ovr_err,   0);
        send_body(8'h22, 1'b0, 0);
        send_bit(1'b0, 0);
        check("ovr_pulse", ovr_err,   1);
        check("ovr_frm",   frm_err,   0);
        check("ovr_data",  out_data,  8'h11);
        check("ovr_valid", out_valid, 1);
        out_ready = 1'b1;
        idle_cycle();
        check("ovr_one_cycle",    ovr_err,   0);
        check("ovr_accept_valid", out_valid, 0);
        out_ready = 1'b0;

        // 0xA5 with bit_en every third cycle; left pending for the reset test.
        send_body(8'hA5, 1'b0, 2);
        send_bit(1'b0, 2);
        check("slow_valid", out_valid, 1);
        check("slow_data",  out_data,  8'hA5);
        check("slow_perr",  out_perr,  0);

        // Reset after payload bit 4 of a new frame (start + bits 0..4 of 0xFF).
        send_bit(1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, 0);
        end
        check("mid_busy", busy, 1);
        bit_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("mrst_out_data",  out_data,  0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_busy",      busy,      0);
        check("mrst_errs",      {frm_err, ovr_err, out_perr}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        check("post_rst_busy", busy, 0);

        send_body(8'h5A, 1'b0, 0);
        send_bit(1'b0, 0);
        check("5a_valid", out_valid, 1);
        check("5a_data",  out_data,  8'h5A);
        check("5a_perr",  out_perr,  0);
        check("5a_errs",  {frm_err, ovr_err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
